// File: rtl/pb_soc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pb_soc_pkg
// Description : Shared types and constants for the PicoBlaze SoC interrupt
//               controller and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
package pb_soc_pkg;

  localparam int INT_WIDTH = 8;

  localparam logic [7:0] INT_MASK   = 8'h1B;
  localparam logic [7:0] INT_STATUS = 8'h1C;
  localparam logic [7:0] INT_CLEAR  = 8'h1D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

endpackage
`default_nettype wire

// File: rtl/pb_soc_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pb_soc_sync_edge
// Description : One-bit interrupt source synchronizer with history flop and
//               rising-edge / level event selection.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_soc_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic src_i,
  output logic set_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_prime;
  logic                   r_hist;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // r_prime fills with ones after reset; edges are only trusted once the
  // history flop holds a real synchronized sample, so a source that was
  // already high across reset does not look like a fresh edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync  <= '0;
      r_prime <= '0;
      r_hist  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], src_i};
      r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
      r_hist  <= w_sync;
    end
  end

  assign set_o = EDGE ? (r_prime[SYNC_STAGES] & w_sync & ~r_hist) : w_sync;

endmodule
`default_nettype wire

// File: rtl/pb_soc_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pb_soc_int_ctrl
// Description : Eight-source interrupt controller driving the PicoBlaze
//               interrupt pin with an assert/acknowledge handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_soc_int_ctrl
  import pb_soc_pkg::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [INT_WIDTH-1:0] EDGE_SEL    = 8'hFF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [INT_WIDTH-1:0] irq_src_i,
  input  logic [INT_WIDTH-1:0] int_mask,
  input  logic [INT_WIDTH-1:0] int_clear,
  output logic [INT_WIDTH-1:0] interrupts,
  output logic                 interrupt_o,
  input  logic                 interrupt_ack_i,
  output logic                 active_o
);

  logic [INT_WIDTH-1:0] w_set;
  logic [INT_WIDTH-1:0] r_pending;
  logic                 w_req;
  int_state_t           r_state;
  int_state_t           w_state_next;

  for (genvar g = 0; g < INT_WIDTH; g++) begin : g_src
    pb_soc_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (EDGE_SEL[g])
    ) u_sync_edge (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .src_i   (irq_src_i[g]),
      .set_o   (w_set[g])
    );
  end

  // Set is OR-ed in after the clear so a coincident event is never lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~int_clear) | w_set;
    end
  end

  assign w_req      = |(r_pending & ~int_mask);
  assign interrupts = r_pending;
  assign active_o   = w_req;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_state_next = REQ;
      REQ: begin
        if (interrupt_ack_i) w_state_next = SERVICE;
        else if (!w_req)     w_state_next = IDLE;
      end
      SERVICE: if (|int_clear) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign interrupt_o = (r_state == REQ);

endmodule
`default_nettype wire

// File: tb/tb_pb_soc_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_soc_int_ctrl
// Description : Directed self-checking bench for pb_soc_int_ctrl (all-edge
//               instance plus a bit-7 level-mode instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_soc_int_ctrl;
  import pb_soc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src, mask, clr, ints;
  logic       irq, ack, act;
  logic [7:0] src_l, mask_l, clr_l, ints_l;
  logic       irq_l, ack_l, act_l;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pb_soc_int_ctrl dut (
    .clk_i (clk), .rst_n_i (rst_n), .irq_src_i (src), .int_mask (mask),
    .int_clear (clr), .interrupts (ints), .interrupt_o (irq),
    .interrupt_ack_i (ack), .active_o (act)
  );

  pb_soc_int_ctrl #(.SYNC_STAGES(2), .EDGE_SEL(8'h7F)) dut_lvl (
    .clk_i (clk), .rst_n_i (rst_n), .irq_src_i (src_l), .int_mask (mask_l),
    .int_clear (clr_l), .interrupts (ints_l), .interrupt_o (irq_l),
    .interrupt_ack_i (ack_l), .active_o (act_l)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; src = 8'hFF; mask = 8'hFF; clr = 8'h00; ack = 1'b0;
    src_l = 8'h00; mask_l = 8'hFF; clr_l = 8'h00; ack_l = 1'b0;
    tick(3);
    checks++; if (ints !== 8'h00) begin errors++; $display("FAIL reset_ints: got %h exp 00", ints); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
    mask = 8'h00;
    rst_n = 1'b1;
    tick(6);
    checks++; if (ints !== 8'h00) begin errors++; $display("FAIL reset_exit_ints: got %h exp 00", ints); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_exit_irq: got %b exp 0", irq); end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL reset_exit_act: got %b exp 0", act); end
    src = 8'h00;
    tick(4);
    checks++; if (ints !== 8'h00) begin errors++; $display("FAIL reset_drop_ints: got %h exp 00", ints); end
  endtask

  task automatic test_single_edge;
    mask = 8'hFE;
    src[0] = 1'b1;
    tick(2);
    checks++; if (ints !== 8'h00) begin errors++; $display("FAIL edge_e1_ints: got %h exp 00", ints); end
    tick(1);
    src[0] = 1'b0;
    checks++; if (ints !== 8'h01) begin errors++; $display("FAIL edge_e2_ints: got %h exp 01", ints); end
    checks++; if (act !== 1'b1) begin errors++; $display("FAIL edge_e2_act: got %b exp 1", act); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_e2_irq: got %b exp 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_e3_irq: got %b exp 1", irq); end
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_ack_irq: got %b exp 0", irq); end
    checks++; if (dut.r_state !== SERVICE) begin errors++; $display("FAIL edge_ack_state: got %0d exp %0d", dut.r_state, SERVICE); end
    ack = 1'b1; tick(2); ack = 1'b0;
    checks++; if (dut.r_state !== SERVICE) begin errors++; $display("FAIL edge_svc_hold: got %0d exp %0d", dut.r_state, SERVICE); end
    clr = 8'h01; tick(1); clr = 8'h00;
    checks++; if (ints !== 8'h00) begin errors++; $display("FAIL edge_clr_ints: got %h exp 00", ints); end
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL edge_clr_state: got %0d exp %0d", dut.r_state, IDLE); end
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_no_rereq: got %b exp 0", irq); end
  endtask

  task automatic test_masking;
    mask = 8'hFF;
    src[3] = 1'b1; tick(3); src[3] = 1'b0;
    checks++; if (ints !== 8'h08) begin errors++; $display("FAIL mask_ints: got %h exp 08", ints); end
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq: got %b exp 0", irq); end
    mask = 8'hF7; tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b exp 1", irq); end
    ack = 1'b1; tick(1); ack = 1'b0;
    clr = 8'h08; tick(1); clr = 8'h00;
    checks++; if (dut.r_state !== IDLE || ints !== 8'h00) begin errors++; $display("FAIL mask_cleanup: got state %0d ints %h exp 0 00", dut.r_state, ints); end
    tick(2);
  endtask

  task automatic test_withdraw;
    src[3] = 1'b1; tick(3); src[3] = 1'b0; tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wd_req: got %b exp 1", irq); end
    mask = 8'hFF; tick(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wd_irq: got %b exp 0", irq); end
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL wd_state: got %0d exp %0d", dut.r_state, IDLE); end
    mask = 8'hF7; tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wd_rereq: got %b exp 1", irq); end
    mask = 8'hFF; ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (dut.r_state !== SERVICE) begin errors++; $display("FAIL wd_ack_state: got %0d exp %0d", dut.r_state, SERVICE); end
    clr = 8'h08; tick(1); clr = 8'h00;
    checks++; if (dut.r_state !== IDLE || ints !== 8'h00) begin errors++; $display("FAIL wd_cleanup: got state %0d ints %h exp 0 00", dut.r_state, ints); end
    tick(2);
  endtask

  task automatic test_collision;
    mask = 8'hFB;
    src[2] = 1'b1; tick(3); src[2] = 1'b0; tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL col_req: got %b exp 1", irq); end
    ack = 1'b1; tick(1); ack = 1'b0;
    tick(3);
    src[2] = 1'b1; tick(2);
    clr = 8'h04; tick(1); clr = 8'h00; src[2] = 1'b0;
    checks++; if (ints !== 8'h04) begin errors++; $display("FAIL col_ints: got %h exp 04", ints); end
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL col_state: got %0d exp %0d", dut.r_state, IDLE); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL col_rereq: got %b exp 1", irq); end
    ack = 1'b1; tick(1); ack = 1'b0;
    clr = 8'h04; tick(1); clr = 8'h00;
    checks++; if (ints !== 8'h00) begin errors++; $display("FAIL col_cleanup: got %h exp 00", ints); end
  endtask

  task automatic test_level;
    mask_l = 8'h7F;
    src_l[7] = 1'b1; tick(3);
    checks++; if (ints_l !== 8'h80) begin errors++; $display("FAIL lvl_ints: got %h exp 80", ints_l); end
    tick(1);
    checks++; if (irq_l !== 1'b1) begin errors++; $display("FAIL lvl_req: got %b exp 1", irq_l); end
    ack_l = 1'b1; tick(1); ack_l = 1'b0;
    clr_l = 8'h80; tick(1); clr_l = 8'h00;
    checks++; if (ints_l !== 8'h80) begin errors++; $display("FAIL lvl_clr_held: got %h exp 80", ints_l); end
    checks++; if (dut_lvl.r_state !== IDLE) begin errors++; $display("FAIL lvl_state: got %0d exp %0d", dut_lvl.r_state, IDLE); end
    tick(1);
    checks++; if (irq_l !== 1'b1) begin errors++; $display("FAIL lvl_rereq: got %b exp 1", irq_l); end
    ack_l = 1'b1; tick(1); ack_l = 1'b0;
    src_l[7] = 1'b0; tick(3);
    clr_l = 8'h80; tick(1); clr_l = 8'h00;
    checks++; if (ints_l !== 8'h00) begin errors++; $display("FAIL lvl_clr_drop: got %h exp 00", ints_l); end
    tick(1);
    checks++; if (irq_l !== 1'b0) begin errors++; $display("FAIL lvl_no_req: got %b exp 0", irq_l); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_masking();
    test_withdraw();
    test_collision();
    test_level();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
